// File: rtl/issue_queue_fifo.sv
// In-order issue queue between decode and the reservation stations; any DEPTH >= 2.
// Latency: one cycle push-to-head, no fall-through. Backpressure: issue_ready_o low when full, flags from registered count only.
`timescale 1ns/1ps
module issue_queue_fifo #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 64,
  parameter int AF_MARGIN = 2,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [DATA_W-1:0] issue_data_i,
  output logic              exec_valid_o,
  input  logic              exec_ready_i,
  output logic [DATA_W-1:0] exec_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              almost_full_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-2 depths never touch slots >= DEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign issue_ready_o = (count != FULL_CNT);
  assign exec_valid_o  = (count != '0);
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = exec_valid_o & exec_ready_i;
  assign exec_data_o   = mem[head];
  assign count_o       = count;
  assign almost_full_o = (count >= AF_CNT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; a flush-cycle push must not land.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[tail] <= issue_data_i;
  end

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_n_i) count <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && count == FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(pop && count == '0));
  a_depth_min: assert property (@(posedge clk_i) DEPTH >= 2);
  a_af_margin: assert property (@(posedge clk_i) AF_MARGIN < DEPTH);
`endif

endmodule
